// File: rtl/rvh_l1d_amo_exec.sv
// Executes one LR/SC/AMO request at a time as a read-modify-write on the L1D data bank,
// then returns the old value or the SC status on the ROB writeback channel.
module rvh_l1d_amo_exec #(
    parameter int unsigned XLEN       = 64,
    parameter int unsigned PADDR_W    = 56,
    parameter int unsigned ROB_TAG_W  = 7,
    parameter int unsigned PREG_TAG_W = 7,
    parameter int unsigned STU_OP_W   = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  amo_req_vld_i,
    output logic                  amo_req_rdy_o,
    input  logic [ROB_TAG_W-1:0]  amo_req_rob_tag_i,
    input  logic [PREG_TAG_W-1:0] amo_req_prd_i,
    input  logic [STU_OP_W-1:0]   amo_req_opcode_i,
    input  logic [PADDR_W-1:0]    amo_req_paddr_i,
    input  logic [XLEN-1:0]       amo_req_data_i,
    input  logic                  amo_req_sc_rt_check_succ_i,
    output logic                  bank_rd_req_vld_o,
    output logic [PADDR_W-1:0]    bank_rd_req_paddr_o,
    input  logic                  bank_rd_req_rdy_i,
    input  logic                  bank_rd_resp_vld_i,
    input  logic [XLEN-1:0]       bank_rd_resp_data_i,
    output logic                  bank_wr_req_vld_o,
    output logic [PADDR_W-1:0]    bank_wr_req_paddr_o,
    output logic [XLEN-1:0]       bank_wr_req_data_o,
    output logic [XLEN/8-1:0]     bank_wr_req_mask_o,
    input  logic                  bank_wr_req_rdy_i,
    output logic                  rob_wb_vld_o,
    output logic [ROB_TAG_W-1:0]  rob_wb_rob_tag_o,
    output logic [PREG_TAG_W-1:0] rob_wb_prd_o,
    output logic [XLEN-1:0]       rob_wb_data_o,
    input  logic                  rob_wb_rdy_i
);
    localparam int unsigned HALF   = XLEN / 2;
    localparam int unsigned MASK_W = XLEN / 8;

    localparam logic [STU_OP_W-1:0] STU_LRW      = STU_OP_W'(1);
    localparam logic [STU_OP_W-1:0] STU_LRD      = STU_OP_W'(2);
    localparam logic [STU_OP_W-1:0] STU_SCW      = STU_OP_W'(3);
    localparam logic [STU_OP_W-1:0] STU_SCD      = STU_OP_W'(4);
    localparam logic [STU_OP_W-1:0] STU_AMOSWAPW = STU_OP_W'(5);
    localparam logic [STU_OP_W-1:0] STU_AMOSWAPD = STU_OP_W'(6);
    localparam logic [STU_OP_W-1:0] STU_AMOADDW  = STU_OP_W'(7);
    localparam logic [STU_OP_W-1:0] STU_AMOADDD  = STU_OP_W'(8);
    localparam logic [STU_OP_W-1:0] STU_AMOANDW  = STU_OP_W'(9);
    localparam logic [STU_OP_W-1:0] STU_AMOANDD  = STU_OP_W'(10);
    localparam logic [STU_OP_W-1:0] STU_AMOORW   = STU_OP_W'(11);
    localparam logic [STU_OP_W-1:0] STU_AMOORD   = STU_OP_W'(12);
    localparam logic [STU_OP_W-1:0] STU_AMOXORW  = STU_OP_W'(13);
    localparam logic [STU_OP_W-1:0] STU_AMOXORD  = STU_OP_W'(14);
    localparam logic [STU_OP_W-1:0] STU_AMOMAXW  = STU_OP_W'(15);
    localparam logic [STU_OP_W-1:0] STU_AMOMAXD  = STU_OP_W'(16);
    localparam logic [STU_OP_W-1:0] STU_AMOMAXUW = STU_OP_W'(17);
    localparam logic [STU_OP_W-1:0] STU_AMOMAXUD = STU_OP_W'(18);
    localparam logic [STU_OP_W-1:0] STU_AMOMINW  = STU_OP_W'(19);
    localparam logic [STU_OP_W-1:0] STU_AMOMIND  = STU_OP_W'(20);
    localparam logic [STU_OP_W-1:0] STU_AMOMINUW = STU_OP_W'(21);
    localparam logic [STU_OP_W-1:0] STU_AMOMINUD = STU_OP_W'(22);

    typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WB} state_e;

    state_e                state_q, state_d;
    logic [STU_OP_W-1:0]   op_q;
    logic [PADDR_W-1:0]    paddr_q;
    logic [XLEN-1:0]       src_q;
    logic [ROB_TAG_W-1:0]  rob_tag_q;
    logic [PREG_TAG_W-1:0] prd_q;
    logic                  sc_succ_q;
    logic [MASK_W-1:0]     mask_q;
    logic [XLEN-1:0]       wr_data_q;
    logic [XLEN-1:0]       wb_data_q;

    logic                  req_hsk_c;
    logic                  req_word_c;
    logic                  is_word_c, is_lr_c, is_sc_c, skip_wr_c;
    logic [HALF-1:0]       old_lane_c;
    logic [XLEN-1:0]       old_c, src_c, new_c, wr_data_c, wb_data_c;

    // Word ops are the odd-numbered encodings in this table
    function automatic logic op_is_word(input logic [STU_OP_W-1:0] op);
        return op[0];
    endfunction

    assign req_hsk_c  = amo_req_vld_i && amo_req_rdy_o;
    assign req_word_c = op_is_word(amo_req_opcode_i);
    assign is_word_c  = op_is_word(op_q);
    assign is_lr_c    = (op_q == STU_LRW) || (op_q == STU_LRD);
    assign is_sc_c    = (op_q == STU_SCW) || (op_q == STU_SCD);
    assign skip_wr_c  = is_lr_c || (is_sc_c && !sc_succ_q);

    // Word operands are sign-extended so one 64-bit ALU serves both widths
    always_comb begin
        old_lane_c = paddr_q[2] ? bank_rd_resp_data_i[XLEN-1:HALF] : bank_rd_resp_data_i[HALF-1:0];
        old_c      = is_word_c ? {{HALF{old_lane_c[HALF-1]}}, old_lane_c} : bank_rd_resp_data_i;
        src_c      = is_word_c ? {{HALF{src_q[HALF-1]}}, src_q[HALF-1:0]} : src_q;
        new_c      = src_c;
        case (op_q)
            STU_AMOADDW, STU_AMOADDD: new_c = old_c + src_c;
            STU_AMOANDW, STU_AMOANDD: new_c = old_c & src_c;
            STU_AMOORW,  STU_AMOORD:  new_c = old_c | src_c;
            STU_AMOXORW, STU_AMOXORD: new_c = old_c ^ src_c;
            STU_AMOMAXW, STU_AMOMAXD:   new_c = ($signed(src_c) > $signed(old_c)) ? src_c : old_c;
            STU_AMOMINW, STU_AMOMIND:   new_c = ($signed(src_c) < $signed(old_c)) ? src_c : old_c;
            STU_AMOMAXUW, STU_AMOMAXUD: new_c = (src_c > old_c) ? src_c : old_c;
            STU_AMOMINUW, STU_AMOMINUD: new_c = (src_c < old_c) ? src_c : old_c;
            default:                    new_c = src_c;
        endcase
        if (!is_word_c)
            wr_data_c = new_c;
        else if (paddr_q[2])
            wr_data_c = {new_c[HALF-1:0], bank_rd_resp_data_i[HALF-1:0]};
        else
            wr_data_c = {bank_rd_resp_data_i[XLEN-1:HALF], new_c[HALF-1:0]};
        if (is_sc_c)
            wb_data_c = sc_succ_q ? '0 : XLEN'(1);
        else
            wb_data_c = old_c;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (amo_req_vld_i) state_d = RD_REQ;
            RD_REQ:  if (bank_rd_req_rdy_i) state_d = RD_WAIT;
            RD_WAIT: if (bank_rd_resp_vld_i) state_d = skip_wr_c ? WB : WR_REQ;
            WR_REQ:  if (bank_wr_req_rdy_i) state_d = WB;
            WB:      if (rob_wb_rdy_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Payload registers need no reset: they are only observed behind a valid
    always_ff @(posedge clk) begin
        if (req_hsk_c) begin
            op_q      <= amo_req_opcode_i;
            paddr_q   <= amo_req_paddr_i;
            src_q     <= amo_req_data_i;
            rob_tag_q <= amo_req_rob_tag_i;
            prd_q     <= amo_req_prd_i;
            sc_succ_q <= amo_req_sc_rt_check_succ_i;
            if (!req_word_c)
                mask_q <= '1;
            else if (amo_req_paddr_i[2])
                mask_q <= {{(MASK_W/2){1'b1}}, {(MASK_W/2){1'b0}}};
            else
                mask_q <= {{(MASK_W/2){1'b0}}, {(MASK_W/2){1'b1}}};
        end
        if (state_q == RD_WAIT && bank_rd_resp_vld_i) begin
            wr_data_q <= wr_data_c;
            wb_data_q <= wb_data_c;
        end
    end

    assign amo_req_rdy_o       = (state_q == IDLE);
    assign bank_rd_req_vld_o   = (state_q == RD_REQ);
    assign bank_rd_req_paddr_o = {paddr_q[PADDR_W-1:3], 3'b000};
    assign bank_wr_req_vld_o   = (state_q == WR_REQ);
    assign bank_wr_req_paddr_o = {paddr_q[PADDR_W-1:3], 3'b000};
    assign bank_wr_req_data_o  = wr_data_q;
    assign bank_wr_req_mask_o  = mask_q;
    assign rob_wb_vld_o        = (state_q == WB);
    assign rob_wb_rob_tag_o    = rob_tag_q;
    assign rob_wb_prd_o        = prd_q;
    assign rob_wb_data_o       = wb_data_q;

    logic unused_paddr_lsb;
    assign unused_paddr_lsb = ^paddr_q[1:0];
endmodule

// File: tb/tb_rvh_l1d_amo_exec.sv
// Directed self-checking bench for rvh_l1d_amo_exec with hand-computed expected values.
module tb_rvh_l1d_amo_exec;
    localparam logic [4:0] LRD = 5'd2, SCW = 5'd3, SCD = 5'd4, SWAPW = 5'd5, ADDW = 5'd7,
                           ADDD = 5'd8, XORD = 5'd14, MAXD = 5'd16, MAXUD = 5'd18,
                           MINW = 5'd19, MINUW = 5'd21;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        amo_req_vld_i = 1'b0;
    logic        amo_req_rdy_o;
    logic [6:0]  amo_req_rob_tag_i = '0;
    logic [6:0]  amo_req_prd_i = '0;
    logic [4:0]  amo_req_opcode_i = '0;
    logic [55:0] amo_req_paddr_i = '0;
    logic [63:0] amo_req_data_i = '0;
    logic        amo_req_sc_rt_check_succ_i = 1'b0;
    logic        bank_rd_req_vld_o;
    logic [55:0] bank_rd_req_paddr_o;
    logic        bank_rd_req_rdy_i = 1'b1;
    logic        bank_rd_resp_vld_i = 1'b1;
    logic [63:0] bank_rd_resp_data_i = '0;
    logic        bank_wr_req_vld_o;
    logic [55:0] bank_wr_req_paddr_o;
    logic [63:0] bank_wr_req_data_o;
    logic [7:0]  bank_wr_req_mask_o;
    logic        bank_wr_req_rdy_i = 1'b1;
    logic        rob_wb_vld_o;
    logic [6:0]  rob_wb_rob_tag_o;
    logic [6:0]  rob_wb_prd_o;
    logic [63:0] rob_wb_data_o;
    logic        rob_wb_rdy_i = 1'b1;

    int n_assert = 0;
    int n_fail   = 0;
    int wr_hs    = 0;
    int wb_hs    = 0;

    rvh_l1d_amo_exec dut (
        .clk(clk), .rst(rst),
        .amo_req_vld_i(amo_req_vld_i), .amo_req_rdy_o(amo_req_rdy_o),
        .amo_req_rob_tag_i(amo_req_rob_tag_i), .amo_req_prd_i(amo_req_prd_i),
        .amo_req_opcode_i(amo_req_opcode_i), .amo_req_paddr_i(amo_req_paddr_i),
        .amo_req_data_i(amo_req_data_i), .amo_req_sc_rt_check_succ_i(amo_req_sc_rt_check_succ_i),
        .bank_rd_req_vld_o(bank_rd_req_vld_o), .bank_rd_req_paddr_o(bank_rd_req_paddr_o),
        .bank_rd_req_rdy_i(bank_rd_req_rdy_i), .bank_rd_resp_vld_i(bank_rd_resp_vld_i),
        .bank_rd_resp_data_i(bank_rd_resp_data_i),
        .bank_wr_req_vld_o(bank_wr_req_vld_o), .bank_wr_req_paddr_o(bank_wr_req_paddr_o),
        .bank_wr_req_data_o(bank_wr_req_data_o), .bank_wr_req_mask_o(bank_wr_req_mask_o),
        .bank_wr_req_rdy_i(bank_wr_req_rdy_i),
        .rob_wb_vld_o(rob_wb_vld_o), .rob_wb_rob_tag_o(rob_wb_rob_tag_o),
        .rob_wb_prd_o(rob_wb_prd_o), .rob_wb_data_o(rob_wb_data_o), .rob_wb_rdy_i(rob_wb_rdy_i)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst && bank_wr_req_vld_o && bank_wr_req_rdy_i) wr_hs++;
        if (!rst && rob_wb_vld_o && rob_wb_rdy_i) wb_hs++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One request with all ready signals high; the bank answers the read the cycle after it is accepted
    task automatic run_op(input string name, input logic [4:0] op, input logic [55:0] pa,
                          input logic [63:0] src, input logic sc_ok, input logic [63:0] rdd,
                          input logic exp_wr, input logic [63:0] exp_wd, input logic [7:0] exp_mask,
                          input logic [63:0] exp_wb);
        int wr_cyc = -1;
        int wb_cyc = -1;
        logic [63:0] wd = '0;
        logic [63:0] wbd = '0;
        logic [7:0]  mk = '0;
        logic [6:0]  tg = '0;
        logic [6:0]  pr = '0;
        bank_rd_resp_data_i        = rdd;
        amo_req_opcode_i           = op;
        amo_req_paddr_i            = pa;
        amo_req_data_i             = src;
        amo_req_sc_rt_check_succ_i = sc_ok;
        amo_req_rob_tag_i          = 7'(op + 5'd3);
        amo_req_prd_i              = 7'(op + 5'd9);
        check({name, " rdy_c0"}, 64'(amo_req_rdy_o), 64'd1);
        amo_req_vld_i = 1'b1;
        tick();
        amo_req_vld_i = 1'b0;
        amo_req_rob_tag_i = '0;
        amo_req_prd_i     = '0;
        check({name, " rd_vld_c1"}, 64'(bank_rd_req_vld_o), 64'd1);
        check({name, " rd_addr"}, 64'(bank_rd_req_paddr_o), 64'({pa[55:3], 3'b000}));
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) tick();
            if (bank_wr_req_vld_o && wr_cyc < 0) begin
                wr_cyc = c; wd = bank_wr_req_data_o; mk = bank_wr_req_mask_o;
            end
            if (rob_wb_vld_o && wb_cyc < 0) begin
                wb_cyc = c; wbd = rob_wb_data_o; tg = rob_wb_rob_tag_o; pr = rob_wb_prd_o;
            end
        end
        check({name, " wr_cycle"}, 64'(wr_cyc), exp_wr ? 64'd3 : 64'(-1));
        if (exp_wr) begin
            check({name, " wr_data"}, wd, exp_wd);
            check({name, " wr_mask"}, 64'(mk), 64'(exp_mask));
        end
        check({name, " wb_cycle"}, 64'(wb_cyc), exp_wr ? 64'd4 : 64'd3);
        check({name, " wb_data"}, wbd, exp_wb);
        check({name, " wb_tag"}, 64'(tg), 64'(7'(op + 5'd3)));
        check({name, " wb_prd"}, 64'(pr), 64'(7'(op + 5'd9)));
        check({name, " rdy_end"}, 64'(amo_req_rdy_o), 64'd1);
    endtask

    initial begin
        int wr0, wb0;
        logic [63:0] snap;
        tick(); tick();
        rst = 1'b0;
        check("reset rdy", 64'(amo_req_rdy_o), 64'd1);
        check("reset vlds", 64'({bank_rd_req_vld_o, bank_wr_req_vld_o, rob_wb_vld_o}), 64'd0);
        tick();

        run_op("addw", ADDW, 56'h1004, 64'h5, 1'b0, 64'h00000001_FFFFFFFF,
               1'b1, 64'h00000006_FFFFFFFF, 8'hF0, 64'h1);
        run_op("maxd", MAXD, 56'h2008, 64'h1, 1'b0, 64'hFFFFFFFF_FFFFFFFF,
               1'b1, 64'h1, 8'hFF, 64'hFFFFFFFF_FFFFFFFF);
        run_op("maxud", MAXUD, 56'h2008, 64'h1, 1'b0, 64'hFFFFFFFF_FFFFFFFF,
               1'b1, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, 64'hFFFFFFFF_FFFFFFFF);
        run_op("minuw", MINUW, 56'h2000, 64'h7, 1'b0, 64'h12345678_80000000,
               1'b1, 64'h12345678_00000007, 8'h0F, 64'hFFFFFFFF_80000000);
        run_op("swapw", SWAPW, 56'h10, 64'h11111111_22222222, 1'b0, 64'hAAAAAAAA_BBBBBBBB,
               1'b1, 64'hAAAAAAAA_22222222, 8'h0F, 64'hFFFFFFFF_BBBBBBBB);
        run_op("minw", MINW, 56'h4, 64'h00000000_FFFFFFFF, 1'b0, 64'h00000005_00000000,
               1'b1, 64'hFFFFFFFF_00000000, 8'hF0, 64'h5);
        run_op("xord", XORD, 56'h3F8, 64'hF0F0F0F0_0000FFFF, 1'b0, 64'h0FF00FF0_12345678,
               1'b1, 64'hFF00FF00_1234A987, 8'hFF, 64'h0FF00FF0_12345678);
        run_op("lrd", LRD, 56'h3008, 64'h0, 1'b0, 64'hDEADBEEF_01234567,
               1'b0, 64'h0, 8'h0, 64'hDEADBEEF_01234567);
        run_op("scw_fail", SCW, 56'h3004, 64'h99, 1'b0, 64'h1,
               1'b0, 64'h0, 8'h0, 64'h1);
        run_op("scd_ok", SCD, 56'h3010, 64'hCAFEF00D_12345678, 1'b1, 64'h55,
               1'b1, 64'hCAFEF00D_12345678, 8'hFF, 64'h0);

        // Back-pressure on every channel: outputs must hold and exactly one write and one wb occur
        wr0 = wr_hs; wb0 = wb_hs;
        bank_rd_req_rdy_i = 1'b0; bank_wr_req_rdy_i = 1'b0; rob_wb_rdy_i = 1'b0;
        bank_rd_resp_data_i = 64'h00000000_00000010;
        amo_req_opcode_i = ADDD; amo_req_paddr_i = 56'h5008; amo_req_data_i = 64'h20;
        amo_req_rob_tag_i = 7'h11; amo_req_prd_i = 7'h22;
        amo_req_vld_i = 1'b1;
        tick();
        amo_req_vld_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall rd", 64'({bank_rd_req_vld_o, amo_req_rdy_o}), 64'b10);
            check("stall rd_addr", 64'(bank_rd_req_paddr_o), 64'h5008);
            tick();
        end
        bank_rd_req_rdy_i = 1'b1;
        tick();
        bank_rd_req_rdy_i = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            check("stall wr", 64'({bank_wr_req_vld_o, amo_req_rdy_o}), 64'b10);
            check("stall wr_data", bank_wr_req_data_o, 64'h30);
            tick();
        end
        bank_wr_req_rdy_i = 1'b1;
        tick();
        bank_wr_req_rdy_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("stall wb", 64'({rob_wb_vld_o, amo_req_rdy_o}), 64'b10);
            check("stall wb_data", rob_wb_data_o, 64'h10);
            check("stall wb_tag", 64'({rob_wb_rob_tag_o, rob_wb_prd_o}), 64'({7'h11, 7'h22}));
            tick();
        end
        rob_wb_rdy_i = 1'b1;
        tick();
        bank_rd_req_rdy_i = 1'b1; bank_wr_req_rdy_i = 1'b1;
        tick();
        check("stall wr_count", 64'(wr_hs - wr0), 64'd1);
        check("stall wb_count", 64'(wb_hs - wb0), 64'd1);
        check("stall rdy_after", 64'(amo_req_rdy_o), 64'd1);

        // Reset while waiting on read data aborts the op
        wr0 = wr_hs; wb0 = wb_hs;
        bank_rd_resp_vld_i = 1'b0;
        amo_req_opcode_i = ADDD; amo_req_paddr_i = 56'h6000; amo_req_data_i = 64'h1;
        amo_req_vld_i = 1'b1;
        tick();
        amo_req_vld_i = 1'b0;
        tick();
        snap = 64'({bank_rd_req_vld_o, amo_req_rdy_o});
        check("rst pre state", snap, 64'b00);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bank_rd_resp_vld_i = 1'b1;
        check("rst rdy_after", 64'(amo_req_rdy_o), 64'd1);
        for (int i = 0; i < 4; i++) tick();
        check("rst no write", 64'(wr_hs - wr0), 64'd0);
        check("rst no wb", 64'(wb_hs - wb0), 64'd0);
        check("rst idle", 64'({amo_req_rdy_o, bank_rd_req_vld_o, bank_wr_req_vld_o, rob_wb_vld_o}), 64'b1000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
